// File: rtl/axis_pkt_arb_if.sv
// AXI-stream style handshake bundle shared by the packet arbiter inputs and output.
// source drives the beat and val; sink drives rdy back.
interface if_axi_stream #(
  parameter int DAT_BITS = 32,
  parameter int MOD_BITS = 2,
  parameter int CTL_BITS = 8
);
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic [MOD_BITS-1:0] mod;
  logic [CTL_BITS-1:0] ctl;
  logic                sop;
  logic                eop;
  logic                err;

  modport source (output val, dat, mod, ctl, sop, eop, err, input rdy);
  modport sink   (input val, dat, mod, ctl, sop, eop, err, output rdy);
endinterface

// File: rtl/axis_pkt_arb.sv
// Packet-level round-robin arbiter: merges NUM_IN streams onto one registered
// output. A grant is held from the first accepted beat until the eop beat, so
// packets never interleave. Optional macro AXIS_PKT_ARB_TAG_CTL_EN replaces the
// low GRANT_BITS of ctl with the index of the input that supplied the beat.
module axis_pkt_arb #(
  parameter int NUM_IN     = 4,
  parameter int GRANT_BITS = $clog2(NUM_IN),
  parameter int DAT_BITS   = 32,
  parameter int MOD_BITS   = 2,
  parameter int CTL_BITS   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  if_axi_stream.sink            i_axi [NUM_IN],
  if_axi_stream.source          o_axi,
  output logic [GRANT_BITS-1:0] o_grant,
  output logic                  o_busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [GRANT_BITS:0]   LP_NUM  = (GRANT_BITS+1)'(NUM_IN);
  localparam logic [GRANT_BITS-1:0] LP_LAST = GRANT_BITS'(NUM_IN - 1);

  // Flattened views of the requester interfaces so they can be indexed by sel.
  logic [NUM_IN-1:0]   w_val;
  logic [NUM_IN-1:0]   w_sop;
  logic [NUM_IN-1:0]   w_eop;
  logic [NUM_IN-1:0]   w_err;
  logic [DAT_BITS-1:0] w_dat [NUM_IN];
  logic [MOD_BITS-1:0] w_mod [NUM_IN];
  logic [CTL_BITS-1:0] w_ctl [NUM_IN];

  state_t                r_state, w_state_next;
  logic [GRANT_BITS-1:0] r_rr_ptr, w_rr_next;
  logic [GRANT_BITS-1:0] r_grant, w_grant_next;
  logic [GRANT_BITS-1:0] w_sel;
  logic [GRANT_BITS:0]   w_sum;
  logic [GRANT_BITS-1:0] w_idx;
  logic                  w_found;
  logic                  w_ld_en;
  logic                  w_acc;
  logic [CTL_BITS-1:0]   w_ctl_in;

  logic                  r_val;
  logic [DAT_BITS-1:0]   r_dat;
  logic [MOD_BITS-1:0]   r_mod;
  logic [CTL_BITS-1:0]   r_ctl;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_err;

  // The output register can take a beat when empty or draining this cycle.
  assign w_ld_en = ~r_val | o_axi.rdy;
  assign w_acc   = w_found & w_ld_en & w_val[w_sel] & ~i_rst;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      assign w_val[gi] = i_axi[gi].val;
      assign w_sop[gi] = i_axi[gi].sop;
      assign w_eop[gi] = i_axi[gi].eop;
      assign w_err[gi] = i_axi[gi].err;
      assign w_dat[gi] = i_axi[gi].dat;
      assign w_mod[gi] = i_axi[gi].mod;
      assign w_ctl[gi] = i_axi[gi].ctl;
      // Only the selected input sees rdy; held low while reset is asserted.
      assign i_axi[gi].rdy = w_ld_en & w_found & ~i_rst &
                             (w_sel == GRANT_BITS'(gi));
    end
  endgenerate

  // Grant selection: locked to the current packet owner, else a round-robin
  // search starting at rr_ptr (loop runs downwards so the nearest match wins).
  always_comb begin
    w_sel   = r_grant;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    if (r_state == LOCKED) begin
      w_found = 1'b1;
    end else begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        w_sum = {1'b0, r_rr_ptr} + (GRANT_BITS+1)'(k);
        if (w_sum >= LP_NUM) begin
          w_sum = w_sum - LP_NUM;
        end
        w_idx = w_sum[GRANT_BITS-1:0];
        if (w_val[w_idx]) begin
          w_sel   = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  // Next-state: an accepted eop releases the grant and rotates priority past it.
  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr_ptr;
    w_grant_next = r_grant;
    if (w_acc) begin
      w_grant_next = w_sel;
      if (w_eop[w_sel]) begin
        w_state_next = IDLE;
        w_rr_next    = (w_sel == LP_LAST) ? '0 : w_sel + GRANT_BITS'(1);
      end else begin
        w_state_next = LOCKED;
      end
    end
  end

  // ctl of the accepted beat, optionally tagged with its source index.
  always_comb begin
    w_ctl_in = w_ctl[w_sel];
`ifdef AXIS_PKT_ARB_TAG_CTL_EN
    w_ctl_in[GRANT_BITS-1:0] = w_sel;
`else
`endif
  end

  // Arbitration state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_next;
      r_grant  <= w_grant_next;
    end
  end

  // One-entry output stage: load on accept, otherwise drain when taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_val <= 1'b0;
      r_dat <= '0;
      r_mod <= '0;
      r_ctl <= '0;
      r_sop <= 1'b0;
      r_eop <= 1'b0;
      r_err <= 1'b0;
    end else if (w_acc) begin
      r_val <= 1'b1;
      r_dat <= w_dat[w_sel];
      r_mod <= w_mod[w_sel];
      r_ctl <= w_ctl_in;
      r_sop <= w_sop[w_sel];
      r_eop <= w_eop[w_sel];
      r_err <= w_err[w_sel];
    end else if (o_axi.rdy) begin
      r_val <= 1'b0;
    end
  end

  assign o_axi.val = r_val;
  assign o_axi.dat = r_dat;
  assign o_axi.mod = r_mod;
  assign o_axi.ctl = r_ctl;
  assign o_axi.sop = r_sop;
  assign o_axi.eop = r_eop;
  assign o_axi.err = r_err;
  assign o_grant   = r_grant;
  assign o_busy    = (r_state == LOCKED);

endmodule

// File: tb/tb_axis_pkt_arb.sv
// Scoreboard bench for axis_pkt_arb: per-input source queues drive the inputs,
// tests push hand-ordered expected beats, a monitor pops and compares.
module tb_axis_pkt_arb;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] dat;
    logic [1:0]  mod;
    logic [7:0]  ctl;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       busy;
  logic [3:0] in_rdy;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  beat_t src_q [4][$];
  beat_t exp_q [$];
  int    stamp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  if_axi_stream #(.DAT_BITS(32), .MOD_BITS(2), .CTL_BITS(8)) in_if [4] ();
  if_axi_stream #(.DAT_BITS(32), .MOD_BITS(2), .CTL_BITS(8)) out_if ();

  axis_pkt_arb #(.NUM_IN(4), .DAT_BITS(32), .MOD_BITS(2), .CTL_BITS(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_axi  (in_if),
    .o_axi  (out_if),
    .o_grant(grant),
    .o_busy (busy)
  );

  function automatic beat_t mk(int s, int p, int i, int n);
    beat_t b;
    b.src = 2'(s);
    b.dat = {8'(s), 8'(p), 8'(i), 8'h5A};
    b.mod = 2'(i);
    b.ctl = 8'hF0;
    b.sop = (i == 0);
    b.eop = (i == n - 1);
    b.err = (i == 1);
    return b;
  endfunction

  task automatic send_pkt(int s, int p, int n);
    for (int i = 0; i < n; i++) src_q[s].push_back(mk(s, p, i, n));
  endtask

  task automatic expect_pkt(int s, int p, int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = mk(s, p, i, n);
`ifdef AXIS_PKT_ARB_TAG_CTL_EN
      b.ctl = 8'hF0 | 8'(s);
`endif
      exp_q.push_back(b);
    end
  endtask

  // Source drivers: present queue head, pop after an observed handshake.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      assign in_rdy[gi] = in_if[gi].rdy;
      initial begin
        logic  acc;
        beat_t h;
        in_if[gi].val = 1'b0;
        in_if[gi].dat = '0;
        in_if[gi].mod = '0;
        in_if[gi].ctl = '0;
        in_if[gi].sop = 1'b0;
        in_if[gi].eop = 1'b0;
        in_if[gi].err = 1'b0;
        forever begin
          @(negedge clk);
          acc = in_if[gi].val && in_if[gi].rdy;
          @(posedge clk);
          #1;
          if (acc && src_q[gi].size() > 0) void'(src_q[gi].pop_front());
          if (src_q[gi].size() > 0) begin
            h = src_q[gi][0];
            in_if[gi].val = 1'b1;
            in_if[gi].dat = h.dat;
            in_if[gi].mod = h.mod;
            in_if[gi].ctl = h.ctl;
            in_if[gi].sop = h.sop;
            in_if[gi].eop = h.eop;
            in_if[gi].err = h.err;
          end else begin
            in_if[gi].val = 1'b0;
          end
        end
      end
    end
  endgenerate

  // Monitor: compare every output transfer, and check stability under stall.
  initial begin
    beat_t e, act, snap;
    logic  held = 1'b0;
    forever begin
      @(negedge clk);
      act = {grant, out_if.dat, out_if.mod, out_if.ctl, out_if.sop, out_if.eop, out_if.err};
      if (held && !rst) begin
        checks++;
        if (out_if.val !== 1'b1 || act !== snap) begin
          errors++;
          $display("FAIL hold: got val=%b beat=%h want val=1 beat=%h", out_if.val, act, snap);
        end
      end
      held = out_if.val && !out_if.rdy && !rst;
      snap = act;
      if (out_if.val && out_if.rdy && !rst) begin
        stamp_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h want nothing", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat: got src=%0d dat=%h mod=%h ctl=%h sop=%b eop=%b err=%b want src=%0d dat=%h mod=%h ctl=%h sop=%b eop=%b err=%b",
                     grant, out_if.dat, out_if.mod, out_if.ctl, out_if.sop, out_if.eop, out_if.err,
                     e.src, e.dat, e.mod, e.ctl, e.sop, e.eop, e.err);
          end else begin
            $display("beat src=%0d dat=%h ctl=%h sop=%b eop=%b", grant, out_if.dat, out_if.ctl, out_if.sop, out_if.eop);
          end
          checks++;
          if (busy !== !e.eop) begin
            errors++;
            $display("FAIL busy_at_beat: got %b want %b", busy, !e.eop);
          end
        end
      end
    end
  end

  task automatic wait_drain(string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding want 0", name, exp_q.size());
    end
  endtask

  task automatic check_stamps(string name, int n);
    checks++;
    if (stamp_q.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d beats want %0d", name, stamp_q.size(), n);
    end else if (stamp_q[n-1] - stamp_q[0] != n - 1) begin
      errors++;
      $display("FAIL %s_gap: got span %0d cycles want %0d", name, stamp_q[n-1] - stamp_q[0], n - 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    out_if.rdy = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Idle after reset: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_if.val !== 1'b0 || in_rdy !== 4'b0 || grant !== 2'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle: got val=%b rdy=%b grant=%0d busy=%b want 0 0000 0 0", out_if.val, in_rdy, grant, busy);
      end
    end

    // All inputs stream single-beat packets: strict 0,1,2,3 rotation, no gaps.
    out_if.rdy = 1'b1;
    stamp_q.delete();
    @(negedge clk);
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < 4; s++) begin
        send_pkt(s, p, 1);
        expect_pkt(s, p, 1);
      end
    wait_drain("rr_single");
    check_stamps("rr_single", 12);

    // Inputs 0 and 2 with 3-beat packets: 0's packet whole, then 2's.
    stamp_q.delete();
    @(negedge clk);
    send_pkt(0, 4, 3);
    send_pkt(2, 4, 3);
    expect_pkt(0, 4, 3);
    expect_pkt(2, 4, 3);
    wait_drain("two_pkts");
    check_stamps("two_pkts", 6);
    // rr_ptr is now 3.

    // Reset mid-packet: input 0 locked with its first beat stalled in the output.
    out_if.rdy = 1'b0;
    @(negedge clk);
    send_pkt(0, 5, 4);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_if.val !== 1'b1 || out_if.dat !== 32'h0005005A || grant !== 2'd0) begin
      errors++;
      $display("FAIL stall_locked: got busy=%b val=%b dat=%h grant=%0d want 1 1 0005005a 0", busy, out_if.val, out_if.dat, grant);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    for (int s = 0; s < 4; s++) src_q[s].delete();
    #1;
    checks++;
    if (out_if.val !== 1'b0 || busy !== 1'b0 || in_rdy !== 4'b0) begin
      errors++;
      $display("FAIL reset_abort: got val=%b busy=%b rdy=%b want 0 0 0000", out_if.val, busy, in_rdy);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    out_if.rdy = 1'b1;

    // After reset rr_ptr is 0, so input 1 goes before input 3.
    @(negedge clk);
    send_pkt(3, 6, 1);
    send_pkt(1, 6, 1);
    expect_pkt(1, 6, 1);
    expect_pkt(3, 6, 1);
    wait_drain("post_reset");

    // Input 1 4-beat packet under toggling back-pressure; input 3 waits for eop.
    @(negedge clk);
    send_pkt(1, 7, 4);
    send_pkt(3, 7, 1);
    expect_pkt(1, 7, 4);
    expect_pkt(3, 7, 1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1 out_if.rdy = ~out_if.rdy;
    end
    out_if.rdy = 1'b1;
    wait_drain("backpressure");

    repeat (3) @(negedge clk);
    checks++;
    if (out_if.val !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: got val=%b busy=%b want 0 0", out_if.val, busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
